// File: rtl/multi_channel_controller.sv
// multi_channel_controller
//   Time-multiplexed note controller. On each frame tick one FSM walks
//   channels 0..NUM_CHANNELS-1 and, for each enabled channel, starts a new
//   note, continues the current note, or only advances the envelope. The
//   shared pattern/pitch/duration/envelope units are addressed by o_channel.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_tick_stb, i_note_stb  frame tick (starts a pass), note-rate strobe
//   i_channel_enable        per-channel enable; 0 skips the channel
//   o_channel               channel being served
//   o_pattern_enable / i_pattern_valid            pattern fetch handshake
//   o_pitch_lookup_enable / i_pitch_lookup_valid  pitch lookup handshake
//   o_duration_enable, o_duration_load, i_duration_running  duration control
//   o_envelope_enable, o_envelope_load, i_envelope_valid    envelope control
//   o_rom_source            shared ROM owner: 00 none, 01 pattern, 10 envelope
//   o_valid, o_valid_channel  one-cycle update pulse and its channel
//   o_busy                  state is not IDLE
//   o_overrun               sticky: tick arrived while busy
//   o_error                 sticky: a wait state timed out
module multi_channel_controller #(
    parameter int NUM_CHANNELS = 4,
    parameter int WAIT_TIMEOUT = 0,
    parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_tick_stb,
    input  logic                    i_note_stb,
    input  logic [NUM_CHANNELS-1:0] i_channel_enable,
    output logic [CH_W-1:0]         o_channel,
    output logic                    o_pattern_enable,
    input  logic                    i_pattern_valid,
    output logic                    o_pitch_lookup_enable,
    input  logic                    i_pitch_lookup_valid,
    output logic                    o_duration_enable,
    output logic                    o_duration_load,
    input  logic                    i_duration_running,
    output logic                    o_envelope_enable,
    output logic                    o_envelope_load,
    input  logic                    i_envelope_valid,
    output logic [1:0]              o_rom_source,
    output logic                    o_valid,
    output logic [CH_W-1:0]         o_valid_channel,
    output logic                    o_busy,
    output logic                    o_overrun,
    output logic                    o_error
);

    typedef enum logic [3:0] {
        S_IDLE, S_DISPATCH, S_CONTINUE, S_ADVANCE_ENV,
        S_EN_PATTERN, S_WAIT_PATTERN, S_EN_PITCH, S_WAIT_PITCH,
        S_LOAD_DUR, S_LOAD_ENV, S_WAIT_ENV, S_VALID
    } state_t;

    localparam logic [CH_W-1:0] LAST_CH    = CH_W'(NUM_CHANNELS - 1);
    localparam int              EN_W       = 1 << CH_W;
    localparam logic [31:0]     WAIT_LIMIT = 32'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

    state_t          state, state_next;
    logic            note_pending;
    logic [31:0]     wait_cnt;
    logic [EN_W-1:0] en_pad;
    logic            ch_enabled, last_ch, is_wait, wait_valid, timeout, chan_step;

    // Pad the enable vector so any CH_W-bit channel index is in range.
    assign en_pad     = EN_W'(i_channel_enable);
    assign ch_enabled = en_pad[o_channel];
    assign last_ch    = (o_channel == LAST_CH);

    always_comb begin
        is_wait    = 1'b0;
        wait_valid = 1'b0;
        case (state)
            S_WAIT_PATTERN: begin is_wait = 1'b1; wait_valid = i_pattern_valid;      end
            S_WAIT_PITCH:   begin is_wait = 1'b1; wait_valid = i_pitch_lookup_valid; end
            S_WAIT_ENV:     begin is_wait = 1'b1; wait_valid = i_envelope_valid;     end
            default:        ;
        endcase
    end

    // Expiry on the last allowed wait cycle; a valid on that same cycle wins.
    assign timeout = (WAIT_TIMEOUT > 0) && is_wait && !wait_valid && (wait_cnt == WAIT_LIMIT);

    always_comb begin
        state_next = state;
        chan_step  = 1'b0;
        case (state)
            S_IDLE:
                if (i_tick_stb) state_next = S_DISPATCH;
            S_DISPATCH:
                if (!ch_enabled) begin
                    if (last_ch) state_next = S_IDLE;
                    else         chan_step  = 1'b1;
                end else if (note_pending && i_duration_running) begin
                    state_next = S_CONTINUE;
                end else if (note_pending) begin
                    state_next = S_EN_PATTERN;
                end else begin
                    state_next = S_ADVANCE_ENV;
                end
            S_CONTINUE:     state_next = S_ADVANCE_ENV;
            S_ADVANCE_ENV:  state_next = S_WAIT_ENV;
            S_EN_PATTERN:   state_next = S_WAIT_PATTERN;
            S_EN_PITCH:     state_next = S_WAIT_PITCH;
            S_LOAD_DUR:     state_next = S_LOAD_ENV;
            S_LOAD_ENV:     state_next = S_WAIT_ENV;
            S_WAIT_PATTERN, S_WAIT_PITCH, S_WAIT_ENV:
                if (wait_valid) begin
                    case (state)
                        S_WAIT_PATTERN: state_next = S_EN_PITCH;
                        S_WAIT_PITCH:   state_next = S_LOAD_DUR;
                        default:        state_next = S_VALID;
                    endcase
                end else if (timeout) begin
                    // Abandon this channel without a VALID pulse.
                    state_next = last_ch ? S_IDLE : S_DISPATCH;
                    chan_step  = !last_ch;
                end
            S_VALID: begin
                state_next = last_ch ? S_IDLE : S_DISPATCH;
                chan_step  = !last_ch;
            end
            default:        state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= S_IDLE;
            o_channel       <= '0;
            o_rom_source    <= 2'b00;
            o_valid_channel <= '0;
            o_overrun       <= 1'b0;
            o_error         <= 1'b0;
            note_pending    <= 1'b0;
            wait_cnt        <= '0;
        end else begin
            state <= state_next;

            if (state == S_IDLE && i_tick_stb) begin
                note_pending <= i_note_stb;
                o_channel    <= '0;
            end else if (chan_step) begin
                o_channel <= o_channel + 1'b1;
            end

            if (i_tick_stb && state != S_IDLE) o_overrun <= 1'b1;
            if (timeout)                       o_error   <= 1'b1;

            if (state == S_EN_PATTERN)               o_rom_source <= 2'b01;
            else if (state == S_LOAD_ENV)            o_rom_source <= 2'b10;
            else if (state == S_VALID || timeout)    o_rom_source <= 2'b00;

            if (state_next == S_VALID) o_valid_channel <= o_channel;

            if (state_next != state) wait_cnt <= '0;
            else if (is_wait)        wait_cnt <= wait_cnt + 32'd1;
        end
    end

    assign o_pattern_enable      = (state == S_EN_PATTERN);
    assign o_pitch_lookup_enable = (state == S_EN_PITCH);
    assign o_duration_enable     = (state == S_CONTINUE) || (state == S_LOAD_DUR);
    assign o_duration_load       = (state == S_LOAD_DUR);
    assign o_envelope_enable     = (state == S_ADVANCE_ENV) || (state == S_LOAD_ENV);
    assign o_envelope_load       = (state == S_LOAD_ENV);
    assign o_valid               = (state == S_VALID);
    assign o_busy                = (state != S_IDLE);

endmodule

// File: tb/tb_multi_channel_controller.sv
// Self-checking bench for multi_channel_controller (3 channels, timeout 5).
// The reference model derives, from per-channel path lengths, the cycle of
// every o_valid pulse, the o_rom_source timeline, the pass end and flags.
module tb_multi_channel_controller;

    localparam int N    = 3;
    localparam int T    = 5;
    localparam int MAXC = 200;

    logic         clk = 1'b0;
    logic         i_rst = 1'b0, i_tick_stb = 1'b0, i_note_stb = 1'b0;
    logic [N-1:0] i_channel_enable = '1;
    logic         i_pattern_valid = 1'b0, i_pitch_lookup_valid = 1'b0;
    logic         i_duration_running = 1'b0, i_envelope_valid = 1'b0;
    logic [1:0]   o_channel, o_valid_channel, o_rom_source;
    logic         o_pattern_enable, o_pitch_lookup_enable, o_duration_enable;
    logic         o_duration_load, o_envelope_enable, o_envelope_load;
    logic         o_valid, o_busy, o_overrun, o_error;

    always #5 clk = ~clk;

    multi_channel_controller #(.NUM_CHANNELS(N), .WAIT_TIMEOUT(T)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_tick_stb(i_tick_stb), .i_note_stb(i_note_stb),
        .i_channel_enable(i_channel_enable), .o_channel(o_channel),
        .o_pattern_enable(o_pattern_enable), .i_pattern_valid(i_pattern_valid),
        .o_pitch_lookup_enable(o_pitch_lookup_enable), .i_pitch_lookup_valid(i_pitch_lookup_valid),
        .o_duration_enable(o_duration_enable), .o_duration_load(o_duration_load),
        .i_duration_running(i_duration_running), .o_envelope_enable(o_envelope_enable),
        .o_envelope_load(o_envelope_load), .i_envelope_valid(i_envelope_valid),
        .o_rom_source(o_rom_source), .o_valid(o_valid), .o_valid_channel(o_valid_channel),
        .o_busy(o_busy), .o_overrun(o_overrun), .o_error(o_error)
    );

    int checks = 0, errors = 0;

    // Pass configuration: delays are the wait-cycle index on which valid rises.
    bit       cfg_note;
    bit [N-1:0] cfg_en;
    bit       cfg_run[N];
    int       dp[N], dq[N], de[N];

    // Model results.
    int exp_vch[MAXC];
    int rom_ev[MAXC];
    int exp_end, exp_pat, exp_dload, exp_cont;
    bit exp_err;

    // Responder: valid inputs after the configured delay, running per channel.
    initial begin
        int pk, qk, ek, pd, qd, ed;
        pk = -1; qk = -1; ek = -1; pd = 0; qd = 0; ed = 0;
        forever begin
            @(negedge clk);
            i_duration_running = (o_channel < N) ? cfg_run[o_channel] : 1'b0;
            if (o_pattern_enable) begin
                pk = 0; pd = dp[o_channel]; i_pattern_valid = 1'b0;
            end else if (pk >= 0) begin
                i_pattern_valid = (pk == pd);
                pk = (pk == pd || pk > 40) ? -1 : pk + 1;
            end else i_pattern_valid = 1'b0;
            if (o_pitch_lookup_enable) begin
                qk = 0; qd = dq[o_channel]; i_pitch_lookup_valid = 1'b0;
            end else if (qk >= 0) begin
                i_pitch_lookup_valid = (qk == qd);
                qk = (qk == qd || qk > 40) ? -1 : qk + 1;
            end else i_pitch_lookup_valid = 1'b0;
            if (o_envelope_enable) begin
                ek = 0; ed = de[o_channel]; i_envelope_valid = 1'b0;
            end else if (ek >= 0) begin
                i_envelope_valid = (ek == ed);
                ek = (ek == ed || ek > 40) ? -1 : ek + 1;
            end else i_envelope_valid = 1'b0;
        end
    end

    task automatic set_defaults();
        cfg_note = 1'b0;
        cfg_en   = '1;
        for (int ch = 0; ch < N; ch++) begin
            cfg_run[ch] = 1'b0; dp[ch] = 0; dq[ch] = 0; de[ch] = 0;
        end
    endtask

    // Cycle 0 = tick cycle. Each channel's service starts at cycle s.
    task automatic build_model();
        int s, w, v;
        for (int c = 0; c < MAXC; c++) begin exp_vch[c] = -1; rom_ev[c] = -1; end
        s = 1; exp_err = 0; exp_pat = 0; exp_dload = 0; exp_cont = 0;
        for (int ch = 0; ch < N; ch++) begin
            if (!cfg_en[ch]) begin s++; continue; end
            if (cfg_note && !cfg_run[ch]) begin
                exp_pat++;
                w = s + 2;                       // first pattern wait cycle
                rom_ev[w] = 1;
                if (dp[ch] >= T) begin exp_err = 1; s = w + T; rom_ev[s] = 0; continue; end
                w = w + dp[ch] + 2;              // first pitch wait cycle
                if (dq[ch] >= T) begin exp_err = 1; s = w + T; rom_ev[s] = 0; continue; end
                exp_dload++;
                w = w + dq[ch] + 3;              // first envelope wait cycle
                rom_ev[w] = 2;
            end else if (cfg_note) begin
                exp_cont++;
                w = s + 3;
            end else begin
                w = s + 2;
            end
            if (de[ch] >= T) begin exp_err = 1; s = w + T; rom_ev[s] = 0; continue; end
            v = w + de[ch] + 1;
            exp_vch[v] = ch;
            rom_ev[v + 1] = 0;
            s = v + 1;
        end
        exp_end = s;
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst = 1'b1; i_tick_stb = 1'b0;
        @(negedge clk);
        i_rst = 1'b0;
    endtask

    task automatic run_pass(input string name, input int extra_tick);
        int  cur_rom, end_c, n_pat, n_dload, n_den;
        bit  exp_ovr;
        do_reset();
        i_channel_enable = cfg_en;
        build_model();
        cur_rom = 0; end_c = -1; n_pat = 0; n_dload = 0; n_den = 0;
        exp_ovr = (extra_tick > 0) && (extra_tick < exp_end);
        @(negedge clk);
        i_note_stb = cfg_note; i_tick_stb = 1'b1;
        for (int c = 0; c < MAXC; c++) begin
            if (c > 0) begin
                @(negedge clk);
                i_tick_stb = (c == extra_tick);
                i_note_stb = ~cfg_note;          // must not affect the latched note
            end
            if (rom_ev[c] >= 0) cur_rom = rom_ev[c];
            checks++;
            if (o_valid !== (exp_vch[c] >= 0)) begin
                errors++;
                $display("FAIL %s valid cyc=%0d: got %b want %b", name, c, o_valid, exp_vch[c] >= 0);
            end
            if (exp_vch[c] >= 0 && o_valid === 1'b1) begin
                checks++;
                if (o_valid_channel !== 2'(exp_vch[c])) begin
                    errors++;
                    $display("FAIL %s valid_channel cyc=%0d: got %0d want %0d", name, c, o_valid_channel, exp_vch[c]);
                end
            end
            checks++;
            if (o_rom_source !== 2'(cur_rom)) begin
                errors++;
                $display("FAIL %s rom_source cyc=%0d: got %b want %0d", name, c, o_rom_source, cur_rom);
            end
            n_pat   += int'(o_pattern_enable);
            n_dload += int'(o_duration_load);
            n_den   += int'(o_duration_enable);
            if (c > 0 && o_busy === 1'b0) begin end_c = c; break; end
        end
        i_tick_stb = 1'b0;
        checks++;
        if (end_c != exp_end) begin
            errors++;
            $display("FAIL %s pass_end: got cycle %0d want %0d", name, end_c, exp_end);
        end
        checks++;
        if (o_error !== exp_err) begin
            errors++;
            $display("FAIL %s error_flag: got %b want %b", name, o_error, exp_err);
        end
        checks++;
        if (o_overrun !== exp_ovr) begin
            errors++;
            $display("FAIL %s overrun_flag: got %b want %b", name, o_overrun, exp_ovr);
        end
        checks++;
        if (n_pat != exp_pat || n_dload != exp_dload || n_den != exp_dload + exp_cont) begin
            errors++;
            $display("FAIL %s strobe_counts: got pat=%0d load=%0d den=%0d want %0d %0d %0d",
                     name, n_pat, n_dload, n_den, exp_pat, exp_dload, exp_dload + exp_cont);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({o_channel, o_rom_source, o_valid_channel} !== 6'b0) begin
            errors++;
            $display("FAIL reset_regs: got ch=%0d rom=%b vch=%0d want 0", o_channel, o_rom_source, o_valid_channel);
        end
        checks++;
        if ({o_pattern_enable, o_pitch_lookup_enable, o_duration_enable, o_duration_load,
             o_envelope_enable, o_envelope_load, o_valid, o_busy, o_overrun, o_error} !== 10'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0", {o_pattern_enable, o_pitch_lookup_enable,
                     o_duration_enable, o_duration_load, o_envelope_enable, o_envelope_load,
                     o_valid, o_busy, o_overrun, o_error});
        end
    endtask

    task automatic test_env_only();
        set_defaults();
        run_pass("env_only", -1);
    endtask

    task automatic test_new_note();
        set_defaults();
        cfg_note = 1'b1; cfg_en = 3'b001; dp[0] = 3;
        run_pass("new_note", -1);
        set_defaults();
        cfg_note = 1'b1; dp[1] = 1; dq[1] = 2; de[2] = 3;
        run_pass("new_note_all", -1);
    endtask

    task automatic test_continue();
        set_defaults();
        cfg_note = 1'b1;
        for (int ch = 0; ch < N; ch++) cfg_run[ch] = 1'b1;
        de[1] = 2;
        run_pass("continue", -1);
    endtask

    task automatic test_disabled();
        set_defaults();
        cfg_en = 3'b010;
        run_pass("disabled_mix", -1);
        set_defaults();
        cfg_en = 3'b000;
        run_pass("all_disabled", -1);
    endtask

    task automatic test_timeout();
        set_defaults();
        cfg_note = 1'b1; dp[0] = 9; cfg_run[1] = 1'b1; dp[2] = T - 1;
        run_pass("timeout_pattern", -1);
        set_defaults();
        cfg_note = 1'b1; cfg_en = 3'b101; dq[0] = T; de[2] = T - 1;
        run_pass("timeout_pitch", -1);
        set_defaults();
        de[2] = 7;
        run_pass("timeout_env_last", -1);
    endtask

    task automatic test_overrun();
        set_defaults();
        cfg_note = 1'b1; cfg_run[2] = 1'b1;
        run_pass("overrun", 3);
        do_reset();
        checks++;
        if (o_overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_cleared: got %b want 0", o_overrun);
        end
    endtask

    task automatic test_reset_mid_pass();
        set_defaults();
        de[0] = 4;
        do_reset();
        i_channel_enable = cfg_en;
        @(negedge clk);
        i_note_stb = 1'b0; i_tick_stb = 1'b1;
        @(negedge clk); i_tick_stb = 1'b0;      // cycle 1 DISPATCH
        @(negedge clk);                         // cycle 2 ADVANCE_ENV
        @(negedge clk);                         // cycle 3 WAIT_ENV
        @(negedge clk); i_rst = 1'b1;           // cycle 4 WAIT_ENV
        @(negedge clk); i_rst = 1'b0;
        checks++;
        if ({o_channel, o_rom_source, o_valid_channel, o_pattern_enable, o_pitch_lookup_enable,
             o_duration_enable, o_duration_load, o_envelope_enable, o_envelope_load,
             o_valid, o_busy, o_overrun, o_error} !== 16'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got ch=%0d rom=%b busy=%b valid=%b", o_channel, o_rom_source, o_busy, o_valid);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_quiet cyc=%0d: got valid=%b busy=%b want 0 0", c, o_valid, o_busy);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            set_defaults();
            cfg_note = 1'($urandom_range(0, 1));
            cfg_en   = 3'($urandom_range(0, 7));
            for (int ch = 0; ch < N; ch++) begin
                cfg_run[ch] = 1'($urandom_range(0, 1));
                dp[ch] = $urandom_range(0, T);
                dq[ch] = $urandom_range(0, T);
                de[ch] = $urandom_range(0, T);
            end
            run_pass($sformatf("random%0d", it), ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : -1);
        end
    endtask

    initial begin
        set_defaults();
        test_reset();
        test_env_only();
        test_new_note();
        test_continue();
        test_disabled();
        test_timeout();
        test_overrun();
        test_reset_mid_pass();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_channel_controller.md
# multi_channel_controller

Time-multiplexed successor to the single-channel note controller: one FSM serves `NUM_CHANNELS` voices in turn over a shared pattern sequencer, pitch lookup, duration bank and envelope bank. On every tick strobe it walks channels 0..N-1. For each enabled channel it runs one of three sequences: start a new note, continue the current note, or advance the envelope only. The shared units are addressed by `o_channel`. The block also adds per-channel enable, overrun detection and wait-state timeout.

## Interface
- `NUM_CHANNELS`, default 4: number of voices, must be ≥1.
- `WAIT_TIMEOUT`, default 0: maximum cycles spent in any wait state. 0 disables the timeout.
- `CH_W`, derived: max(1, $clog2(NUM_CHANNELS)).

Ports:
- `i_clk` in 1: single clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_tick_stb` in 1: frame tick; starts one pass over all channels.
- `i_note_stb` in 1: note-rate strobe, sampled together with `i_tick_stb`.
- `i_channel_enable` in NUM_CHANNELS: bit n=0 makes the pass skip channel n.
- `o_channel` out CH_W: channel currently being served; selects the shared units.
- `o_pattern_enable` out 1 / `i_pattern_valid` in 1: pattern fetch request / completion.
- `o_pitch_lookup_enable` out 1 / `i_pitch_lookup_valid` in 1: pitch lookup request / completion.
- `o_duration_enable` out 1, `o_duration_load` out 1, `i_duration_running` in 1: duration counter control and status for `o_channel`.
- `o_envelope_enable` out 1, `o_envelope_load` out 1, `i_envelope_valid` in 1: envelope control and completion.
- `o_rom_source` out 2: shared-ROM owner. 00 = none, 01 = pattern, 10 = envelope.
- `o_valid` out 1: one-cycle pulse when a channel's outputs are updated.
- `o_valid_channel` out CH_W: channel that `o_valid` refers to.
- `o_busy` out 1: high whenever the state is not IDLE.
- `o_overrun` out 1: sticky flag; a tick arrived while busy.
- `o_error` out 1: sticky flag; a wait state timed out.

## Operation
- States: IDLE, DISPATCH, CONTINUE, ADVANCE_ENV, EN_PATTERN, WAIT_PATTERN, EN_PITCH, WAIT_PITCH, LOAD_DUR, LOAD_ENV, WAIT_ENV, VALID.
- IDLE: on `i_tick_stb`, latch `i_note_stb` into `note_pending`, set channel to 0, go to DISPATCH.
- DISPATCH, channel disabled: no strobes. If channel = N-1 go to IDLE, else channel+1 and stay in DISPATCH.
- DISPATCH, channel enabled:
  - `note_pending` and `i_duration_running` → CONTINUE.
  - `note_pending` and not running → EN_PATTERN.
  - otherwise → ADVANCE_ENV.
- CONTINUE: `o_duration_enable`=1 → ADVANCE_ENV.
- ADVANCE_ENV: `o_envelope_enable`=1 → WAIT_ENV.
- EN_PATTERN: `o_pattern_enable`=1, rom_source←01 → WAIT_PATTERN. WAIT_PATTERN exits on `i_pattern_valid` → EN_PITCH.
- EN_PITCH: `o_pitch_lookup_enable`=1 → WAIT_PITCH. WAIT_PITCH exits on `i_pitch_lookup_valid` → LOAD_DUR.
- LOAD_DUR: `o_duration_enable`=`o_duration_load`=1 → LOAD_ENV.
- LOAD_ENV: `o_envelope_enable`=`o_envelope_load`=1, rom_source←10 → WAIT_ENV. WAIT_ENV exits on `i_envelope_valid` → VALID.
- VALID: `o_valid`=1, `o_valid_channel`=channel, rom_source←00. If channel = N-1 go to IDLE, else channel+1 → DISPATCH.
- Strobe outputs are Moore decodes of the state, high for exactly one cycle. `o_rom_source` and `o_channel` are registered.
- Overrun: `i_tick_stb` while not IDLE sets `o_overrun`; that tick is otherwise ignored.
- Timeout (WAIT_TIMEOUT>0): a cycle counter clears on entry to each wait state. If it reaches WAIT_TIMEOUT before the valid input arrives:
  - set `o_error` and rom_source←00;
  - skip VALID for this channel (no `o_valid` pulse);
  - go to the next channel, or to IDLE after channel N-1.
- A valid input that arrives on the same cycle as expiry wins; no error is raised.
- The channel counter saturates its pass at N-1 and never wraps mid-pass. Non-power-of-two N is legal.

## Timing
- Reset values: state IDLE, `o_channel`=0, `o_rom_source`=00, all strobes 0, `o_valid`=0, `o_valid_channel`=0, `o_busy`=0, `o_overrun`=0, `o_error`=0, `note_pending`=0.
- Reset asserted mid-pass aborts the pass immediately; nothing is pulsed on the following cycle.
- Tick sampled at cycle 0, each valid input high on the first cycle of its wait state:
  - new-note path: `o_valid` at cycle 9;
  - continue path: `o_valid` at cycle 5;
  - envelope-only path: `o_valid` at cycle 4.
- Each later enabled channel starts at the cycle after the previous VALID. Each disabled channel costs one DISPATCH cycle.
- `i_duration_running` is sampled only in DISPATCH. All valid inputs are level-sampled only in their own wait state.

## Test plan
- N=4, all channels enabled, tick with note_stb=0, valids immediate → four `o_valid` pulses, `o_valid_channel` 0,1,2,3, at cycles 4, 8, 12, 16; `o_busy` low at cycle 17.
- N=1, note_stb=1, running=0, pattern valid delayed 3 cycles → `o_rom_source` 01 from cycle 3, 10 after LOAD_ENV, 00 after VALID; `o_valid` at cycle 12; `o_duration_load` pulses once.
- N=2, `i_channel_enable`=2'b01 → only channel 0 pulses `o_valid`; pass ends one cycle later than with N=1.
- Second tick during a pass → `o_overrun`=1 and stays 1; pass completes normally; `i_rst` clears the flag.
- WAIT_TIMEOUT=5, `i_pattern_valid` never asserted, N=2 → `o_error`=1, no `o_valid` for channel 0, channel 1 served normally.
- `i_rst` asserted while in WAIT_ENV → next cycle all outputs at reset values, IDLE, no `o_valid`.
